// File: rtl/regfile_mp.sv
// Multi-read-port register file: registered reads with write-first bypass,
// optional hardwired zero register, and a per-register busy scoreboard.
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int NUM_READ  = 2,
    parameter int ZERO_REG0 = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         regWrite,
    input  logic [ADDR_W-1:0]            writeReg,
    input  logic [DATA_W-1:0]            writeData,
    input  logic [NUM_READ-1:0]          readEn,
    input  logic [NUM_READ*ADDR_W-1:0]   readReg,
    output logic [NUM_READ*DATA_W-1:0]   readData,
    output logic [NUM_READ-1:0]          readBusy,
    input  logic                         reserveEn,
    input  logic [ADDR_W-1:0]            reserveReg,
    output logic [DEPTH-1:0]             busyVec
);

    logic [DATA_W-1:0]          mem_q [DEPTH];
    logic [DEPTH-1:0]           busy_q, busy_d;
    logic [DEPTH-1:0]           wr_sel, rsv_sel;
    logic [NUM_READ*DATA_W-1:0] rdata_q, rdata_d;
    logic [NUM_READ-1:0]        rbusy_q, rbusy_d;

    // Decode by comparing against every index, so out-of-range addresses
    // simply match nothing and the zero register never accepts a write.
    always_comb begin
        wr_sel  = '0;
        rsv_sel = '0;
        for (int r = 0; r < DEPTH; r++) begin
            wr_sel[r]  = regWrite && (writeReg == ADDR_W'(r))
                         && !(ZERO_REG0 != 0 && r == 0);
            rsv_sel[r] = reserveEn && (reserveReg == ADDR_W'(r))
                         && !(ZERO_REG0 != 0 && r == 0);
        end
    end

    // A new reservation beats a same-cycle writeback of an older producer.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (rsv_sel[r]) begin
                busy_d[r] = 1'b1;
            end else if (wr_sel[r]) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < DEPTH; r++) begin
                if (wr_sel[r]) begin
                    mem_q[r] <= writeData;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              busy;

        assign addr = readReg[p*ADDR_W +: ADDR_W];

        // Busy is sampled after this cycle's write-clear, before its reserve.
        always_comb begin
            data = '0;
            busy = 1'b0;
            for (int r = 0; r < DEPTH; r++) begin
                if (addr == ADDR_W'(r) && !(ZERO_REG0 != 0 && r == 0)) begin
                    data = wr_sel[r] ? writeData : mem_q[r];
                    busy = busy_q[r] && !wr_sel[r];
                end
            end
        end

        always_comb begin
            rdata_d[p*DATA_W +: DATA_W] = rdata_q[p*DATA_W +: DATA_W];
            rbusy_d[p]                  = rbusy_q[p];
            if (readEn[p]) begin
                rdata_d[p*DATA_W +: DATA_W] = data;
                rbusy_d[p]                  = busy;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            rbusy_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
        end
    end

    assign readData = rdata_q;
    assign readBusy = rbusy_q;
    assign busyVec  = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: default 2-port instance and a
// 4-port / 16-entry / 64-bit instance.
module tb_regfile_mp;

    typedef struct {
        logic [63:0] data;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic        regWrite_a, reserveEn_a;
    logic [4:0]  writeReg_a, reserveReg_a;
    logic [31:0] writeData_a;
    logic [1:0]  readEn_a, readBusy_a;
    logic [9:0]  readReg_a;
    logic [63:0] readData_a;
    logic [31:0] busyVec_a;

    // Instance B: 4 ports, 16 entries, 64-bit
    logic        regWrite_b, reserveEn_b;
    logic [4:0]  writeReg_b, reserveReg_b;
    logic [63:0] writeData_b;
    logic [3:0]  readEn_b, readBusy_b;
    logic [19:0] readReg_b;
    logic [255:0] readData_b;
    logic [15:0] busyVec_b;

    regfile_mp dut_a (
        .clk(clk), .rst_n(rst_n),
        .regWrite(regWrite_a), .writeReg(writeReg_a), .writeData(writeData_a),
        .readEn(readEn_a), .readReg(readReg_a),
        .readData(readData_a), .readBusy(readBusy_a),
        .reserveEn(reserveEn_a), .reserveReg(reserveReg_a),
        .busyVec(busyVec_a)
    );

    regfile_mp #(.DATA_W(64), .ADDR_W(5), .DEPTH(16), .NUM_READ(4), .ZERO_REG0(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .regWrite(regWrite_b), .writeReg(writeReg_b), .writeData(writeData_b),
        .readEn(readEn_b), .readReg(readReg_b),
        .readData(readData_b), .readBusy(readBusy_b),
        .reserveEn(reserveEn_b), .reserveReg(reserveReg_b),
        .busyVec(busyVec_b)
    );

    int checks = 0;
    int errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [1:0] vld_a;
    logic [3:0] vld_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // A read issued on a port produces output at the next edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_a <= '0;
            vld_b <= '0;
        end else begin
            vld_a <= readEn_a;
            vld_b <= readEn_b;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            if (vld_a[p]) begin
                if (qa.size() == 0) begin
                    chk("a_queue_underflow", 64'd1, 64'd0);
                end else begin
                    e = qa.pop_front();
                    chk($sformatf("a_rd%0d", p),
                        {31'd0, readBusy_a[p], readData_a[p*32 +: 32]},
                        {31'd0, e.busy, e.data[31:0]});
                end
            end
        end
        for (int p = 0; p < 4; p++) begin
            if (vld_b[p]) begin
                if (qb.size() == 0) begin
                    chk("b_queue_underflow", 64'd1, 64'd0);
                end else begin
                    e = qb.pop_front();
                    chk($sformatf("b_rd%0d_data", p), readData_b[p*64 +: 64], e.data);
                    chk($sformatf("b_rd%0d_busy", p), {63'd0, readBusy_b[p]}, {63'd0, e.busy});
                end
            end
        end
    end

    task automatic idle();
        regWrite_a = 0; writeReg_a = 0; writeData_a = 0; readEn_a = 0;
        reserveEn_a = 0; reserveReg_a = 0;
        regWrite_b = 0; writeReg_b = 0; writeData_b = 0; readEn_b = 0;
        reserveEn_b = 0; reserveReg_b = 0;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr_a(input int r, input logic [31:0] d);
        regWrite_a = 1; writeReg_a = 5'(r); writeData_a = d;
    endtask

    task automatic rd_a(input int p, input int r, input logic [31:0] d, input logic b);
        readEn_a[p] = 1'b1;
        readReg_a[p*5 +: 5] = 5'(r);
        qa.push_back('{data: {32'd0, d}, busy: b});
    endtask

    task automatic wr_b(input int r, input logic [63:0] d);
        regWrite_b = 1; writeReg_b = 5'(r); writeData_b = d;
    endtask

    task automatic rd_b(input int p, input int r, input logic [63:0] d, input logic b);
        readEn_b[p] = 1'b1;
        readReg_b[p*5 +: 5] = 5'(r);
        qb.push_back('{data: d, busy: b});
    endtask

    initial begin
        idle();
        readReg_a = '0;
        readReg_b = '0;
        #3;
        chk("reset_busyvec_a", {32'd0, busyVec_a}, 64'd0);
        chk("reset_rdata_a", readData_a, 64'd0);
        @(posedge clk); #1; rst_n = 1;

        // Load nonzero state so the mid-cycle reset has something to clear.
        wr_a(9, 32'hA5A5A5A5); reserveEn_a = 1; reserveReg_a = 5'd4; go();
        rd_a(0, 9, 32'hA5A5A5A5, 0); rd_a(1, 4, 32'h0, 1); go();
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        chk("async_rst_rdata", readData_a, 64'd0);
        chk("async_rst_rbusy", {62'd0, readBusy_a}, 64'd0);
        chk("async_rst_busyvec", {32'd0, busyVec_a}, 64'd0);
        @(posedge clk); #1; rst_n = 1;

        for (int r = 1; r < 32; r++) begin
            rd_a(0, r, 32'h0, 0); rd_a(1, r, 32'h0, 0); go();
        end

        wr_a(5, 32'hDEADBEEF); go();
        rd_a(0, 5, 32'hDEADBEEF, 0); go();

        wr_a(7, 32'h12345678); rd_a(0, 7, 32'h12345678, 0); rd_a(1, 7, 32'h12345678, 0); go();

        wr_a(0, 32'hFFFFFFFF); go();
        rd_a(0, 0, 32'h0, 0); rd_a(1, 0, 32'h0, 0);
        reserveEn_a = 1; reserveReg_a = 5'd0; go();
        chk("zero_never_busy", {32'd0, busyVec_a}, 64'd0);

        reserveEn_a = 1; reserveReg_a = 5'd3; go();
        chk("reserve_x3", {32'd0, busyVec_a}, 64'h8);
        rd_a(1, 3, 32'h0, 1); go();
        wr_a(3, 32'h33); rd_a(0, 3, 32'h33, 0); go();
        chk("writeback_clears_x3", {32'd0, busyVec_a}, 64'd0);
        wr_a(3, 32'h44); reserveEn_a = 1; reserveReg_a = 5'd3; rd_a(0, 3, 32'h44, 0); go();
        chk("reserve_wins_x3", {32'd0, busyVec_a}, 64'h8);
        go();
        chk("hold_rdata_p0", {32'd0, readData_a[31:0]}, 64'h44);
        chk("hold_rbusy_p0", {63'd0, readBusy_a[0]}, 64'd0);
        rd_a(0, 3, 32'h44, 1); go();

        wr_b(1, 64'h1111111111111111); go();
        wr_b(2, 64'h22220000FFFF0002); go();
        wr_b(15, 64'hF0F0F0F00F0F0F0F); reserveEn_b = 1; reserveReg_b = 5'd2; go();
        chk("b_busyvec_x2", {48'd0, busyVec_b}, 64'h4);
        rd_b(0, 1, 64'h1111111111111111, 0);
        rd_b(1, 2, 64'h22220000FFFF0002, 1);
        rd_b(2, 15, 64'hF0F0F0F00F0F0F0F, 0);
        rd_b(3, 0, 64'h0, 0);
        go();
        wr_b(20, 64'h0BAD0BAD0BAD0BAD); reserveEn_b = 1; reserveReg_b = 5'd20;
        rd_b(0, 20, 64'h0, 0); rd_b(1, 4, 64'h0, 0); go();
        chk("b_oor_reserve_ignored", {48'd0, busyVec_b}, 64'h4);
        rd_b(0, 20, 64'h0, 0); rd_b(1, 4, 64'h0, 0);
        rd_b(2, 2, 64'h22220000FFFF0002, 1); rd_b(3, 15, 64'hF0F0F0F00F0F0F0F, 0);
        go();

        go(); go();
        chk("a_queue_drained", 64'(qa.size()), 64'd0);
        chk("b_queue_drained", 64'(qb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
